// File: rtl/d_sc_param_lfs_divider_seq.sv
// Sequential parallel GF(2) polynomial divider: folds P_LVL message bits per beat into a
// GF_ORDER-bit remainder and reports the remainder after CW_BEATS accepted beats.
module d_sc_param_lfs_divider_seq #(
    parameter int unsigned       GF_ORDER = 12,
    parameter int unsigned       P_LVL    = 8,
    parameter logic [GF_ORDER:0] POLY     = 13'h1053,
    parameter int unsigned       CW_BEATS = 256
) (
    input  logic                i_clk,
    input  logic                i_RESET,
    input  logic                i_start,
    input  logic                i_msg_valid,
    input  logic [P_LVL-1:0]    i_message,
    output logic                o_busy,
    output logic [GF_ORDER-1:0] o_remainder,
    output logic                o_rem_valid,
    output logic                o_rem_nonzero,
    output logic                o_err
);

    localparam int unsigned      CNT_W    = $clog2(CW_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_BEATS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GF_ORDER-1:0] r_q, r_d;
    logic [GF_ORDER-1:0] rem_q, rem_d;
    logic                nz_q, nz_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [GF_ORDER-1:0] r_step;
    logic [P_LVL-1:0]    msg_sh;
    logic                fb;
    logic [CNT_W-1:0]    cnt_base;
    logic                accept;

    // A start restarts the accumulator from zero, so the same-cycle beat folds into 0.
    always_comb begin
        r_step = i_start ? '0 : r_q;
        msg_sh = i_message;
        fb     = 1'b0;
        for (int i = 0; i < int'(P_LVL); i++) begin
            fb     = r_step[GF_ORDER-1];
            r_step = {r_step[GF_ORDER-2:0], msg_sh[P_LVL-1]} ^ (fb ? POLY[GF_ORDER-1:0] : '0);
            msg_sh = msg_sh << 1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        rem_d    = rem_q;
        nz_d     = nz_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        cnt_base = i_start ? '0 : cnt_q;
        accept   = i_msg_valid && (i_start || (state_q == StRun));

        if (accept) begin
            if (cnt_base == LAST_CNT) begin
                state_d = StIdle;
                cnt_d   = '0;
                rem_d   = r_step;
                nz_d    = |r_step;
                valid_d = 1'b1;
            end else begin
                state_d = StRun;
                cnt_d   = cnt_base + CNT_W'(1);
                r_d     = r_step;
            end
        end else if (i_start) begin
            state_d = StRun;
            cnt_d   = '0;
            r_d     = '0;
        end else if (i_msg_valid) begin
            // Beat arrived with no open frame: drop it and flag the violation.
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            rem_q   <= '0;
            nz_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
            nz_q    <= nz_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_busy        = (state_q == StRun);
    assign o_remainder   = rem_q;
    assign o_rem_valid   = valid_q;
    assign o_rem_nonzero = nz_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_d_sc_param_lfs_divider_seq.sv
// Bench: directed scenarios on a small divider instance plus a randomized back-to-back
// regression on a default-polynomial instance, checked against a long-division model.
module tb_d_sc_param_lfs_divider_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: GF_ORDER=4, POLY=x^4+x+1, P_LVL=4, CW_BEATS=2
    logic       rst_s, start_s, mv_s;
    logic [3:0] msg_s;
    logic       busy_s, rv_s, nz_s, err_s;
    logic [3:0] rem_s;

    // Default polynomial instance with a shorter codeword to keep the run short
    localparam int DB = 16;
    logic        rst_d, start_d, mv_d;
    logic [7:0]  msg_d;
    logic        busy_d, rv_d, nz_d, err_d;
    logic [11:0] rem_d;

    d_sc_param_lfs_divider_seq #(
        .GF_ORDER(4), .P_LVL(4), .POLY(5'b10011), .CW_BEATS(2)
    ) dut_s (
        .i_clk(clk), .i_RESET(rst_s), .i_start(start_s), .i_msg_valid(mv_s),
        .i_message(msg_s), .o_busy(busy_s), .o_remainder(rem_s), .o_rem_valid(rv_s),
        .o_rem_nonzero(nz_s), .o_err(err_s)
    );

    d_sc_param_lfs_divider_seq #(
        .GF_ORDER(12), .P_LVL(8), .POLY(13'h1053), .CW_BEATS(DB)
    ) dut_d (
        .i_clk(clk), .i_RESET(rst_d), .i_start(start_d), .i_msg_valid(mv_d),
        .i_message(msg_d), .o_busy(busy_d), .o_remainder(rem_d), .o_rem_valid(rv_d),
        .o_rem_nonzero(nz_d), .o_err(err_d)
    );

    int passed = 0;
    int total  = 0;
    int vcount_s = 0;
    int vcount_d = 0;

    // c(x) mod poly by schoolbook long division; b[0] is the highest-degree coefficient.
    function automatic logic [31:0] poly_mod(input bit b[0:255], input int n, input int gf,
                                             input logic [31:0] poly);
        bit w[0:255];
        logic [31:0] r;
        w = b;
        for (int i = 0; i <= n - gf - 1; i++)
            if (w[i])
                for (int k = 0; k <= gf; k++) w[i+k] = w[i+k] ^ poly[gf-k];
        r = '0;
        for (int j = 0; j < gf; j++)
            if (n - 1 - j >= 0) r[j] = w[n-1-j];
        return r;
    endfunction

    function automatic logic [3:0] ref_s(input logic [3:0] a, input logic [3:0] c);
        bit b[0:255];
        logic [31:0] r;
        for (int i = 0; i < 256; i++) b[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b[k]   = a[3-k];
            b[4+k] = c[3-k];
        end
        r = poly_mod(b, 8, 4, 32'h13);
        return r[3:0];
    endfunction

    task automatic cyc_s(input logic rst, input logic st, input logic mv, input logic [3:0] m);
        rst_s = rst; start_s = st; mv_s = mv; msg_s = m;
        @(posedge clk);
        #1;
        if (rv_s) vcount_s++;
        rst_s = 1'b0; start_s = 1'b0; mv_s = 1'b0;
    endtask

    task automatic cyc_d(input logic st, input logic mv, input logic [7:0] m);
        start_d = st; mv_d = mv; msg_d = m;
        @(posedge clk);
        #1;
        if (rv_d) vcount_d++;
        start_d = 1'b0; mv_d = 1'b0;
    endtask

    task automatic test_reset;
        rst_d = 1'b1;
        cyc_s(1'b1, 1'b0, 1'b0, 4'h0);
        cyc_s(1'b1, 1'b1, 1'b1, 4'hF);
        rst_d = 1'b0;
        total++; if ({busy_s, rem_s, rv_s, nz_s, err_s} !== 8'h00)
            $display("FAIL reset_small: got %b want 00000000", {busy_s, rem_s, rv_s, nz_s, err_s});
            else passed++;
        total++; if ({busy_d, rem_d, rv_d, nz_d, err_d} !== 16'h0000)
            $display("FAIL reset_default: got %h want 0000", {busy_d, rem_d, rv_d, nz_d, err_d});
            else passed++;
    endtask

    task automatic test_basic;
        cyc_s(1'b0, 1'b1, 1'b0, 4'h0);
        total++; if (busy_s !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy_s);
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b1, 4'b1000);
        total++; if (rv_s !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", rv_s);
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b1, 4'b0000);
        total++; if ({rem_s, nz_s, rv_s, busy_s} !== 7'b1011_1_1_0)
            $display("FAIL basic_result: got %b want 1011110", {rem_s, nz_s, rv_s, busy_s});
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b0, 4'h0);
        total++; if ({rem_s, rv_s} !== 5'b1011_0)
            $display("FAIL basic_pulse_hold: got %b want 10110", {rem_s, rv_s});
            else passed++;
    endtask

    task automatic test_multiple;
        cyc_s(1'b0, 1'b1, 1'b1, 4'b0001);
        cyc_s(1'b0, 1'b0, 1'b1, 4'b0011);
        total++; if ({rem_s, nz_s, rv_s} !== 6'b0000_0_1)
            $display("FAIL multiple_zero: got %b want 000001", {rem_s, nz_s, rv_s});
            else passed++;
    endtask

    task automatic test_abort;
        int v0;
        v0 = vcount_s;
        cyc_s(1'b0, 1'b1, 1'b0, 4'h0);
        cyc_s(1'b0, 1'b0, 1'b1, 4'b1111);
        cyc_s(1'b0, 1'b1, 1'b0, 4'h0);
        total++; if ({rv_s, err_s, busy_s} !== 3'b001)
            $display("FAIL abort_silent: got %b want 001", {rv_s, err_s, busy_s});
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b1, 4'b1000);
        cyc_s(1'b0, 1'b0, 1'b1, 4'b0000);
        total++; if (rem_s !== 4'b1011) $display("FAIL abort_rem: got %b want 1011", rem_s);
            else passed++;
        total++; if (vcount_s - v0 !== 1)
            $display("FAIL abort_valid_count: got %0d want 1", vcount_s - v0);
            else passed++;
    endtask

    task automatic test_idle_beat;
        cyc_s(1'b0, 1'b0, 1'b1, 4'b1010);
        total++; if ({err_s, rem_s, busy_s, rv_s} !== 7'b1_1011_0_0)
            $display("FAIL idle_beat: got %b want 1101100", {err_s, rem_s, busy_s, rv_s});
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b0, 4'h0);
        total++; if (err_s !== 1'b0) $display("FAIL idle_err_pulse: got %b want 0", err_s);
            else passed++;
    endtask

    task automatic test_reset_mid;
        int v0;
        v0 = vcount_s;
        cyc_s(1'b0, 1'b1, 1'b0, 4'h0);
        cyc_s(1'b0, 1'b0, 1'b1, 4'b1000);
        cyc_s(1'b1, 1'b0, 1'b0, 4'h0);
        total++; if ({busy_s, rem_s, rv_s, nz_s, err_s} !== 8'h00)
            $display("FAIL reset_mid_outputs: got %b want 00000000",
                     {busy_s, rem_s, rv_s, nz_s, err_s});
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b1, 4'b0000);
        total++; if ({err_s, rv_s, rem_s} !== 6'b1_0_0000)
            $display("FAIL reset_mid_beat: got %b want 100000", {err_s, rv_s, rem_s});
            else passed++;
        total++; if (vcount_s !== v0)
            $display("FAIL reset_mid_no_valid: got %0d want %0d", vcount_s, v0);
            else passed++;
    endtask

    // Start arriving with what would have been the final beat restarts the frame.
    task automatic test_start_on_last;
        logic [3:0] a, c;
        a = 4'($urandom);
        c = 4'($urandom);
        cyc_s(1'b0, 1'b1, 1'b1, 4'($urandom));
        cyc_s(1'b0, 1'b1, 1'b1, a);
        total++; if ({rv_s, busy_s} !== 2'b01)
            $display("FAIL start_on_last_suppress: got %b want 01", {rv_s, busy_s});
            else passed++;
        cyc_s(1'b0, 1'b0, 1'b1, c);
        total++; if ({rv_s, rem_s} !== {1'b1, ref_s(a, c)})
            $display("FAIL start_on_last_rem: got %b want %b", {rv_s, rem_s}, {1'b1, ref_s(a, c)});
            else passed++;
    endtask

    task automatic test_small_random;
        logic [3:0] a, c, e;
        for (int f = 0; f < 40; f++) begin
            a = 4'($urandom);
            c = 4'($urandom);
            e = ref_s(a, c);
            cyc_s(1'b0, 1'b1, 1'b1, a);
            cyc_s(1'b0, 1'b0, 1'b1, c);
            total++; if ({rv_s, rem_s, nz_s} !== {1'b1, e, (e != 4'h0)})
                $display("FAIL small_rand f=%0d: got %b want %b", f, {rv_s, rem_s, nz_s},
                         {1'b1, e, (e != 4'h0)});
                else passed++;
        end
    endtask

    task automatic test_back_to_back;
        bit b[0:255];
        logic [7:0] m;
        logic [31:0] e;
        int v0;
        v0 = vcount_d;
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < 256; i++) b[i] = 1'b0;
            for (int bt = 0; bt < DB; bt++) begin
                if (bt > 0 && $urandom_range(0, 7) == 0) begin
                    cyc_d(1'b0, 1'b0, 8'h00);
                    total++; if (rv_d !== 1'b0)
                        $display("FAIL b2b_bubble_valid f=%0d: got %b want 0", f, rv_d);
                        else passed++;
                end
                m = 8'($urandom);
                for (int k = 0; k < 8; k++) b[bt*8+k] = m[7-k];
                cyc_d(bt == 0, 1'b1, m);
                total++; if (rv_d !== (bt == DB - 1))
                    $display("FAIL b2b_valid f=%0d beat=%0d: got %b want %b", f, bt, rv_d,
                             (bt == DB - 1));
                    else passed++;
            end
            e = poly_mod(b, DB * 8, 12, 32'h1053);
            total++; if ({rem_d, nz_d, busy_d} !== {e[11:0], (e[11:0] != 12'h0), 1'b0})
                $display("FAIL b2b_rem f=%0d: got %h/%b want %h/%b", f, rem_d, nz_d, e[11:0],
                         (e[11:0] != 12'h0));
                else passed++;
        end
        total++; if (vcount_d - v0 !== 1000)
            $display("FAIL b2b_valid_count: got %0d want 1000", vcount_d - v0);
            else passed++;
    endtask

    initial begin
        rst_s = 1'b0; start_s = 1'b0; mv_s = 1'b0; msg_s = '0;
        rst_d = 1'b0; start_d = 1'b0; mv_d = 1'b0; msg_d = '0;
        test_reset;
        test_basic;
        test_multiple;
        test_abort;
        test_idle_beat;
        test_reset_mid;
        test_start_on_last;
        test_small_random;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/d_sc_param_lfs_divider_seq.md
# d_sc_param_lfs_divider_seq

Sequential, parametrised parallel polynomial-division engine for the BCH syndrome-calculator path. It accepts a codeword as a stream of P_LVL-bit beats and divides it by a programmable GF(2) polynomial, accumulating the remainder across a configurable number of beats. It replaces the fixed-polynomial combinational dividers that the syndrome stage instantiates. It adds frame control, beat counting, a registered result with a valid strobe, a nonzero flag and protocol-error detection.

## Interface
- GF_ORDER, 12: remainder width; degree of the divisor polynomial.
- P_LVL, 8: message bits consumed per accepted beat.
- POLY, 13'h1053: divisor polynomial, GF_ORDER+1 bits, bit k is the coefficient of x^k. POLY[GF_ORDER] must be 1.
- CW_BEATS, 256: beats per codeword, ≥1. The counter width is clog2(CW_BEATS+1).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; opens a new codeword and clears the accumulator.
- i_msg_valid  in  1  a message beat is present.
- i_message  in  P_LVL  beat data. Bit P_LVL-1 is the earliest (highest-degree) bit.
- o_busy  out  1  high while a codeword is open (RUN state).
- o_remainder  out  GF_ORDER  last completed remainder; held until the next completion.
- o_rem_valid  out  1  one-cycle pulse when o_remainder updates.
- o_rem_nonzero  out  1  |o_remainder, registered with o_remainder.
- o_err  out  1  one-cycle pulse on a protocol violation.

## Operation
- Serial step for bit m on remainder r: r' = {r[GF_ORDER-2:0], m} ^ (r[GF_ORDER-1] ? POLY[GF_ORDER-1:0] : 0).
- Per accepted beat, apply the step P_LVL times combinationally, from i_message[P_LVL-1] down to i_message[0].
- Result: the remainder of c(x) mod POLY, where c(x) is the codeword with its first-received bit as the highest degree.
- States:
  - IDLE: accumulator is don't-care; beats are not accepted.
  - RUN: accumulator r and beat counter cnt are live.
- Transitions and rules:
  - i_start in any state: enter RUN with r=0, cnt=0. If i_msg_valid is also high in that cycle, the beat is processed as beat 0 (r=step(0,beat), cnt=1).
  - RUN with i_msg_valid: r updates and cnt increments.
  - When the accepted beat is beat CW_BEATS-1: register o_remainder=r', o_rem_nonzero=|r', and pulse o_rem_valid. Return to IDLE.
  - CW_BEATS=1 with i_start and i_msg_valid together: the codeword completes in that cycle.
  - i_start during RUN (mid-frame) aborts the open frame silently. No o_rem_valid and no o_err; the new frame begins as described above.
  - i_start in the completing cycle: start takes priority. No completion is reported, and the beat is beat 0 of the new frame.
  - i_msg_valid in IDLE without i_start: the beat is dropped, o_err pulses, and o_remainder is unchanged.
- o_remainder and o_rem_nonzero change only on completion or reset.

## Timing
- Reset values: o_busy=0, o_remainder=0, o_rem_valid=0, o_rem_nonzero=0, o_err=0. State is IDLE and cnt=0.
- i_RESET takes priority over i_start and i_msg_valid. Reset mid-frame discards the frame, and no o_rem_valid is issued.
- Throughput: one beat per cycle, with no stalls or bubbles. There is no back-pressure; upstream must honour o_busy.
- Latency: when the final beat is accepted at edge t, o_remainder, o_rem_nonzero and o_rem_valid are visible after edge t.
  - o_rem_valid is high for exactly one cycle.
  - o_busy falls at that same edge.
- Back-to-back frames: i_start may be asserted in the cycle after completion, giving zero idle cycles between codewords.
- o_busy rises at the edge that samples i_start.
- o_err is registered; it is visible one edge after the offending beat.
- Critical path: P_LVL chained step stages. No pipelining inside a beat.

## Test plan
All scenarios use GF_ORDER=4, POLY=5'b10011, P_LVL=4, CW_BEATS=2 unless stated.
- Basic division: start, then beats 4'b1000 and 4'b0000 -> o_remainder=4'b1011, o_rem_nonzero=1, o_rem_valid high for 1 cycle after beat 2, o_busy=0.
- Codeword is a multiple of POLY: start+beat 4'b0001 in the same cycle, then beat 4'b0011 -> o_remainder=4'b0000, o_rem_nonzero=0, o_rem_valid pulses.
- Mid-frame abort: start, beat 4'b1111, start, then beats 4'b1000 and 4'b0000 -> exactly one o_rem_valid, with o_remainder=4'b1011.
- Idle beat: with no start, i_msg_valid with 4'b1010 -> o_err pulses 1 cycle, o_remainder keeps its prior value, o_busy=0.
- Reset mid-frame: start, beat 4'b1000, i_RESET for 1 cycle, then beat 4'b0000 -> no o_rem_valid, o_err pulses, and all outputs are 0 after reset.
- Default-parameter random regression: 1000 random codewords, back-to-back starts -> every remainder matches a bit-serial reference model, and exactly 1 o_rem_valid per frame.
